// File: rtl/frame_scan_scheduler.sv
// Walks the tracker over every grid cell once per frame_start, queues changed
// cells as {x, y, obj_code} and hands them to the display writer over valid/ready.
module frame_scan_scheduler #(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       frame_start,
    output logic [3:0] scan_x,
    output logic [3:0] scan_y,
    output logic       tracker_en,
    input  logic       diff,
    input  logic [2:0] obj_code,
    output logic       wr_valid,
    output logic [3:0] wr_x,
    output logic [3:0] wr_y,
    output logic [2:0] wr_code,
    input  logic       wr_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] X_LAST   = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST   = 4'(GRID_H - 1);
    localparam logic [PW:0] STALL_AT = (PW + 1)'(FIFO_DEPTH - 1);
    localparam logic [PW:0] FULL     = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     scan_x_reg, scan_y_reg;
    logic [3:0]     px_reg, py_reg;
    logic           in_flight_reg;
    logic           frame_done_reg;
    logic           overrun_reg;
    logic [10:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [PW:0]    count_reg;

    logic issue, done_now, start_ok, last_cell, stall, fifo_empty, push, pop;

    assign fifo_empty = (count_reg == '0);
    // Keep one slot free so the result already in the tracker pipeline always fits.
    assign stall      = (count_reg >= STALL_AT);
    assign last_cell  = (scan_x_reg == X_LAST) && (scan_y_reg == Y_LAST);
    assign start_ok   = frame_start && !frame_done_reg;
    assign push       = in_flight_reg && diff;
    assign pop        = !fifo_empty && wr_ready;

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        done_now   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) state_next = SCAN;
            end
            SCAN: begin
                issue = !stall;
                if (issue && last_cell) state_next = DRAIN;
            end
            DRAIN: begin
                if (!in_flight_reg && fifo_empty) begin
                    state_next = IDLE;
                    done_now   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            scan_x_reg     <= '0;
            scan_y_reg     <= '0;
            px_reg         <= '0;
            py_reg         <= '0;
            in_flight_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            in_flight_reg  <= issue;
            px_reg         <= scan_x_reg;
            py_reg         <= scan_y_reg;
            frame_done_reg <= done_now;
            // The done cycle already shows IDLE but still counts as busy for requests.
            if (frame_start && (state_reg != IDLE || frame_done_reg))
                overrun_reg <= 1'b1;
            if (state_reg == IDLE && start_ok) begin
                scan_x_reg <= '0;
                scan_y_reg <= '0;
            end else if (issue) begin
                if (last_cell) begin
                    scan_x_reg <= '0;
                    scan_y_reg <= '0;
                end else if (scan_x_reg == X_LAST) begin
                    scan_x_reg <= '0;
                    scan_y_reg <= scan_y_reg + 4'd1;
                end else begin
                    scan_x_reg <= scan_x_reg + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr_reg] <= {px_reg, py_reg, obj_code};
                wr_ptr_reg      <= wr_ptr_reg + PW'(1);
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!nrst) !(push && count_reg == FULL));

    assign scan_x     = scan_x_reg;
    assign scan_y     = scan_y_reg;
    assign tracker_en = issue;
    assign wr_valid   = !fifo_empty;
    assign {wr_x, wr_y, wr_code} = mem[rd_ptr_reg];
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_frame_scan_scheduler.sv
// Randomized bench for frame_scan_scheduler: a cell-table tracker stand-in plus a
// queue-based frame model checked against the DUT on every falling edge.
module tb_frame_scan_scheduler;

    localparam int W = 16;
    localparam int H = 12;
    localparam int D = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       frame_start = 1'b0;
    logic       diff = 1'b0;
    logic [2:0] obj_code = 3'd0;
    logic       wr_ready = 1'b0;
    logic [3:0] scan_x, scan_y, wr_x, wr_y;
    logic [2:0] wr_code;
    logic       tracker_en, wr_valid, busy, frame_done, overrun;

    always #5 clk = ~clk;

    frame_scan_scheduler #(.GRID_W(W), .GRID_H(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .nrst(nrst), .frame_start(frame_start),
        .scan_x(scan_x), .scan_y(scan_y), .tracker_en(tracker_en),
        .diff(diff), .obj_code(obj_code),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_code(wr_code),
        .wr_ready(wr_ready), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;

    // Frame model: cells issued so far, pending result, and the changed-cell queue.
    bit          m_busy, m_inflight, m_done, m_overrun;
    int          m_idx, m_fl_idx;
    logic [10:0] m_q[$];
    logic [10:0] model_log[$];
    logic [10:0] dut_log[$];
    bit          cell_diff[N];
    logic [2:0]  cell_code[N];

    function automatic logic [10:0] cell_entry(input int idx, input logic [2:0] code);
        return {4'(idx % W), 4'(idx / W), code};
    endfunction

    function automatic bit exp_te();
        return m_busy && (m_idx < N) && (m_q.size() < D - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_inflight = 0; m_done = 0; m_overrun = 0;
        m_idx = 0; m_fl_idx = 0;
        m_q.delete();
    endtask

    task automatic model_advance();
        bit te, pop, push, done_n;
        logic [10:0] ent;
        if (!nrst) begin
            model_reset();
            return;
        end
        te     = exp_te();
        pop    = (m_q.size() != 0) && wr_ready;
        push   = m_inflight && diff;
        done_n = m_busy && (m_idx == N) && !m_inflight && (m_q.size() == 0);
        ent    = cell_entry(m_fl_idx, obj_code);
        if (pop) begin
            model_log.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (push) m_q.push_back(ent);
        if (frame_start && (m_busy || m_done)) m_overrun = 1;
        m_inflight = te;
        m_fl_idx   = m_idx;
        if (te) m_idx++;
        if (done_n) m_busy = 0;
        else if (!m_busy && frame_start && !m_done) begin
            m_busy = 1;
            m_idx  = 0;
        end
        m_done = done_n;
    endtask

    task automatic check_outputs();
        chk("busy", busy, m_busy);
        chk("tracker_en", tracker_en, exp_te());
        if (m_busy && m_idx < N) begin
            chk("scan_x", scan_x, m_idx % W);
            chk("scan_y", scan_y, m_idx / W);
        end
        chk("wr_valid", wr_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("wr_head", {wr_x, wr_y, wr_code}, m_q[0]);
        chk("frame_done", frame_done, m_done);
        chk("overrun", overrun, m_overrun);
    endtask

    // Called at a falling edge: drive inputs, advance the model, wait for the next falling edge, compare.
    task automatic step(input bit fs, input bit rdy);
        frame_start = fs;
        wr_ready    = rdy;
        if (m_inflight) begin
            diff     = cell_diff[m_fl_idx];
            obj_code = cell_code[m_fl_idx];
        end else begin
            diff     = 1'($urandom);
            obj_code = 3'($urandom);
        end
        if (nrst && wr_valid && rdy) dut_log.push_back({wr_x, wr_y, wr_code});
        model_advance();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic bit ready_for(input int mode, input int s);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            2:       return s >= 50;
            default: return s[0];
        endcase
    endfunction

    task automatic fill_cells(input int pct);
        for (int i = 0; i < N; i++) begin
            cell_diff[i] = ($urandom_range(0, 99) < pct);
            cell_code[i] = 3'($urandom);
        end
    endtask

    task automatic run_frame(input int mode, input int second_start, output int done_step,
                             output int te_cnt, output int wv_cnt, output int first_stall);
        done_step = -1; te_cnt = 0; wv_cnt = 0; first_stall = -1;
        dut_log.delete();
        model_log.delete();
        for (int s = 0; s < 3000; s++) begin
            step((s == 0) || (s == second_start), ready_for(mode, s));
            if (tracker_en) te_cnt++;
            if (wr_valid) wv_cnt++;
            if (busy && !tracker_en && first_stall < 0) first_stall = s;
            if (frame_done) begin
                done_step = s;
                break;
            end
        end
        checks++;
        if (done_step < 0) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected one within 3000 cycles");
        end
        step(0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_scan_x"}, scan_x, 0);
        chk({tag, "_scan_y"}, scan_y, 0);
        chk({tag, "_tracker_en"}, tracker_en, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_entry"}, {wr_x, wr_y, wr_code}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int ds, te, wv, fst, bad;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
        repeat (3) step(0, 1);

        // Empty frame.
        for (int i = 0; i < N; i++) begin cell_diff[i] = 0; cell_code[i] = 3'($urandom); end
        run_frame(0, -1, ds, te, wv, fst);
        chk("empty_te_cycles", te, 192);
        chk("empty_done_step", ds, 194);
        chk("empty_wr_valid_cycles", wv, 0);
        chk("empty_busy_after", busy, 0);
        $display("frame empty: done_step=%0d te=%0d", ds, te);

        // Sparse diffs, (4,4) is scanned before (5,4).
        for (int i = 0; i < N; i++) cell_diff[i] = 0;
        cell_diff[4 * W + 5] = 1; cell_code[4 * W + 5] = 3'd1;
        cell_diff[4 * W + 4] = 1; cell_code[4 * W + 4] = 3'd2;
        run_frame(0, -1, ds, te, wv, fst);
        chk("sparse_dut_count", dut_log.size(), 2);
        chk("sparse_model_count", model_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("sparse_first", dut_log[0], {4'd4, 4'd4, 3'd2});
            chk("sparse_second", dut_log[1], {4'd5, 4'd4, 3'd1});
        end
        if (model_log.size() == 2) chk("sparse_model_first", model_log[0], {4'd4, 4'd4, 3'd2});
        chk("sparse_done_step", ds, 194);
        $display("frame sparse: entries=%0d done_step=%0d", dut_log.size(), ds);

        // Backpressure: every cell changed, writer stalled for 50 cycles.
        for (int i = 0; i < N; i++) begin cell_diff[i] = 1; cell_code[i] = 3'd3; end
        run_frame(2, -1, ds, te, wv, fst);
        chk("bp_dut_count", dut_log.size(), 192);
        chk("bp_model_count", model_log.size(), 192);
        chk("bp_first_stall", fst, 8);
        bad = 0;
        for (int i = 0; i < dut_log.size() && i < N; i++)
            if (dut_log[i] !== cell_entry(i, 3'd3)) bad++;
        chk("bp_order_mismatches", bad, 0);
        $display("frame backpressure: entries=%0d done_step=%0d first_stall=%0d", dut_log.size(), ds, fst);

        // Overrun: second request 20 cycles in, then a clean follow-up frame.
        fill_cells(30);
        run_frame(1, 20, ds, te, wv, fst);
        chk("overrun_set", overrun, 1);
        chk("overrun_te_cycles", te, 192);
        fill_cells(30);
        run_frame(0, -1, ds, te, wv, fst);
        chk("overrun_next_te_cycles", te, 192);
        chk("overrun_sticky", overrun, 1);
        $display("frame overrun: overrun=%0b next_done_step=%0d", overrun, ds);

        // Writer ready toggling with every cell changed.
        for (int i = 0; i < N; i++) begin cell_diff[i] = 1; cell_code[i] = 3'($urandom); end
        run_frame(3, -1, ds, te, wv, fst);
        chk("toggle_dut_count", dut_log.size(), 192);
        $display("frame toggle: entries=%0d done_step=%0d", dut_log.size(), ds);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            fill_cells($urandom_range(0, 100));
            run_frame(1, -1, ds, te, wv, fst);
            chk("random_count", dut_log.size(), model_log.size());
            $display("frame random %0d: entries=%0d done_step=%0d", f, dut_log.size(), ds);
        end

        // Reset in the middle of a scan.
        fill_cells(60);
        step(1, 0);
        repeat (30) step(0, $urandom_range(0, 1));
        nrst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) step(0, 1);
        nrst = 1'b1;
        repeat (5) step(0, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_wr_valid", wr_valid, 0);
        fill_cells(20);
        run_frame(0, -1, ds, te, wv, fst);
        chk("post_rst_te_cycles", te, 192);
        $display("frame after reset: done_step=%0d", ds);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_scan_scheduler.md
Name: frame_scan_scheduler

Overview:
- Sequences one full-grid scan of the frame tracker per game tick.
- Drives the tracker's cell coordinates and enable, and captures each cell's diff/obj_code result.
- Queues changed cells only, as {x, y, obj_code}, in a small FIFO for the display writer, which pops them over a valid/ready handshake.
- Sits between the game-tick logic and the tracker/display-writer pair.

Parameters:
GRID_W, 16, columns per frame; x counts 0..GRID_W-1 (max 16)
GRID_H, 12, rows per frame; y counts 0..GRID_H-1 (max 16)
FIFO_DEPTH, 8, changed-cell queue entries (power of 2, >=4)

Ports:
clk  in  1  system clock, rising-edge
nrst  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, request a scan
scan_x  out  4  column presented to the tracker
scan_y  out  4  row presented to the tracker
tracker_en  out  1  tracker evaluates cell (scan_x, scan_y) this cycle
diff  in  1  tracker result for the cell issued one cycle earlier: cell changed
obj_code  in  3  tracker result for the cell issued one cycle earlier: object code
wr_valid  out  1  FIFO head valid
wr_x  out  4  head entry column
wr_y  out  4  head entry row
wr_code  out  3  head entry object code
wr_ready  in  1  display writer accepts the head entry this cycle
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse, scan complete and FIFO drained
overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset state (async, nrst=0): state IDLE; scan_x=0, scan_y=0; tracker_en=0; FIFO empty; in_flight=0; wr_valid=0; wr_x=0, wr_y=0, wr_code=0; busy=0; frame_done=0; overrun=0.
- Reset mid-scan aborts the scan immediately and discards all FIFO contents.
- States are IDLE, SCAN and DRAIN. All outputs are registered or decoded from registers.
- IDLE:
  - tracker_en=0.
  - frame_start=1 → SCAN, with scan_x=0 and scan_y=0.
- SCAN:
  - tracker_en=1 unless stalled.
  - Stall condition: fifo_count >= FIFO_DEPTH-1. This reserves one slot for the in-flight result.
  - While stalled: tracker_en=0 and coordinates hold.
  - Each non-stalled cycle advances scan_x. At scan_x=GRID_W-1, scan_x wraps to 0 and scan_y increments.
  - Scan order is row-major: x fastest, starting at (0,0).
  - The edge that issues (GRID_W-1, GRID_H-1) moves the state to DRAIN. tracker_en=0 from then on.
- Result pipeline:
  - On each edge, in_flight <= tracker_en, and px/py <= scan_x/scan_y.
  - When in_flight=1 and diff=1, {px, py, obj_code} is pushed into the FIFO.
  - When in_flight=1 and diff=0, nothing is pushed.
  - diff and obj_code are ignored when in_flight=0.
- DRAIN:
  - Stays in DRAIN until in_flight=0 and the FIFO is empty.
  - On that edge: frame_done=1 for exactly one cycle, then → IDLE.
- FIFO:
  - First-in first-out order; wr_valid = !empty; wr_x/wr_y/wr_code show the head entry.
  - The head entry stays stable while wr_valid=1 and wr_ready=0.
  - A pop occurs when wr_valid & wr_ready.
  - Simultaneous push and pop: count unchanged; pop of an empty FIFO is a no-op.
  - Overflow is impossible by the stall rule. Implementation carries an assertion that no push occurs while full.
- frame_start while state != IDLE (including the cycle frame_done is high): ignored and overrun <= 1. overrun clears only on reset.
- Timing with no diffs and no stalls, counting from the edge that samples frame_start:
  - Edges 1..192: tracker_en=1.
  - frame_done is high in the cycle after edge 194.
  - busy falls at edge 194, together with the return to IDLE.

Test Plan:
- Reset mid-scan: hold nrst=0 for 2 cycles during a scan → all outputs at reset values asynchronously; after release, busy=0 and wr_valid=0 until the next frame_start.
- Empty frame: frame_start pulse with diff=0 throughout → 192 tracker_en cycles with scan order (0,0),(1,0)…(15,0),(0,1)…(15,11); wr_valid never 1; frame_done single pulse at edge 194; busy low afterwards.
- Sparse diffs: model returns diff=1 for cells (5,4) code 001 and (4,4) code 010, wr_ready=1 → wr entries (4,4,010) then (5,4,001) in that order; frame_done after both popped.
- Backpressure: all 192 cells diff=1, code 011, wr_ready=0 for 50 cycles then 1 → tracker_en drops once fifo_count reaches 7 and coordinates hold; exactly 192 entries popped in scan order with none lost or duplicated; frame_done only after the last pop.
- Overrun: second frame_start 20 cycles into a scan → scan unaffected and overrun=1 until reset; a frame_start after frame_done starts a new scan normally.
- Simultaneous push/pop at full-1 with wr_ready toggling every cycle → count stays within 0..8, no stall deadlock, order preserved.
